// File: rtl/hex_msg_scroller.sv
// hex_msg_scroller: scrolls a ring of 3-bit character codes across HEX3..HEX0.
// Character set: 000 A, 001 G, 010 P, 011 F, 100 E, 101 H, 110 L, 111 blank.
// Ports: CLOCK_50/RESET_N (async active-low); MSG message codes, char i at
//   bits [3i+2:3i]; LOAD_KEY/STEP_KEY active-low pushbuttons; RUN_SW auto
//   scroll enable; DIR_SW 0=left 1=right; CODE3..CODE0 per-digit codes;
//   POS ring offset; WRAP one-cycle pulse when POS wraps.
// Optional: define HEX_SCROLL_BLINK_EN to blink the digits while paused.
module hex_msg_scroller #(
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 25000000,
    parameter int POS_W    = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    input  logic [3*MSG_LEN-1:0]   MSG,
    input  logic                   LOAD_KEY,
    input  logic                   STEP_KEY,
    input  logic                   RUN_SW,
    input  logic                   DIR_SW,
    output logic [2:0]             CODE3,
    output logic [2:0]             CODE2,
    output logic [2:0]             CODE1,
    output logic [2:0]             CODE0,
    output logic [POS_W-1:0]       POS,
    output logic                   WRAP
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRE_TC   = PW'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);

    typedef enum logic {PAUSE, RUN} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic [2:0]       msg_q [MSG_LEN];
    logic [2:0]       msg_d [MSG_LEN];

    // Key pipelines: two synchronizer flops plus one history flop for edges.
    logic [2:0] load_sq, step_sq;
    logic [1:0] run_sq, dir_sq;

    logic load_fall, step_fall, run_s, dir_s;
    logic do_step, blank;

    assign load_fall = load_sq[2] & ~load_sq[1];
    assign step_fall = step_sq[2] & ~step_sq[1];
    assign run_s     = run_sq[1];
    assign dir_s     = dir_sq[1];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            load_sq <= 3'b111;
            step_sq <= 3'b111;
            run_sq  <= 2'b00;
            dir_sq  <= 2'b00;
            state_q <= PAUSE;
            presc_q <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= 3'b111;
        end else begin
            load_sq <= {load_sq[1:0], LOAD_KEY};
            step_sq <= {step_sq[1:0], STEP_KEY};
            run_sq  <= {run_sq[0], RUN_SW};
            dir_sq  <= {dir_sq[0], DIR_SW};
            state_q <= state_d;
            presc_q <= presc_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= msg_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        msg_d   = msg_q;
        do_step = 1'b0;

        unique case (state_q)
            PAUSE: begin
                if (run_s) state_d = RUN;
                do_step = step_fall;
            end
            RUN: begin
                if (!run_s) begin
                    state_d = PAUSE;
                    presc_d = '0;
                end else if (presc_q == PRE_TC) begin
                    presc_d = '0;
                    do_step = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = PAUSE;
        endcase

        if (do_step) begin
            if (!dir_s) begin
                wrap_d = (pos_q == POS_LAST);
                pos_d  = wrap_d ? '0 : pos_q + 1'b1;
            end else begin
                wrap_d = (pos_q == '0);
                pos_d  = wrap_d ? POS_LAST : pos_q - 1'b1;
            end
        end

        // A load overrides any step landing in the same cycle.
        if (load_fall) begin
            for (int i = 0; i < MSG_LEN; i++) msg_d[i] = MSG[3*i +: 3];
            pos_d   = '0;
            presc_d = '0;
            wrap_d  = 1'b0;
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic [PW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Restart on PAUSE entry so the first half after pausing is visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (state_q == RUN && state_d == PAUSE) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == PRE_TC) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    assign blank = (state_q == PAUSE) && blink_ph_q;
`else
    assign blank = 1'b0;
`endif

    // Digit k shows char (POS + 3 - k) mod MSG_LEN; one subtract suffices
    // because POS < MSG_LEN and MSG_LEN >= 4.
    logic [POS_W:0] idx  [4];
    logic [2:0]     code [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = {1'b0, pos_q} + (POS_W+1)'(3 - k);
            if (idx[k] >= (POS_W+1)'(MSG_LEN))
                idx[k] = idx[k] - (POS_W+1)'(MSG_LEN);
            code[k] = 3'b111;
            for (int i = 0; i < MSG_LEN; i++)
                if (idx[k] == (POS_W+1)'(i)) code[k] = msg_q[i];
            if (blank) code[k] = 3'b111;
        end
    end

    assign CODE3 = code[3];
    assign CODE2 = code[2];
    assign CODE1 = code[1];
    assign CODE0 = code[0];
    assign POS   = pos_q;
    assign WRAP  = wrap_q;

endmodule

// File: tb/tb_hex_msg_scroller.sv
// tb_hex_msg_scroller: scoreboard bench for hex_msg_scroller.
// Expected POS/CODE/WRAP entries are queued as stimulus is driven.
module tb_hex_msg_scroller;

    localparam int ML = 8;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] msg;
    logic        load_k, step_k, run_sw, dir_sw;
    logic [2:0]  c3, c2, c1, c0;
    logic [3:0]  pos;
    logic        wrap;

    always #5 clk = ~clk;

    hex_msg_scroller #(.MSG_LEN(ML), .TICK_DIV(TD), .POS_W(4)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .MSG(msg),
        .LOAD_KEY(load_k), .STEP_KEY(step_k),
        .RUN_SW(run_sw), .DIR_SW(dir_sw),
        .CODE3(c3), .CODE2(c2), .CODE1(c1), .CODE0(c0),
        .POS(pos), .WRAP(wrap)
    );

    typedef struct {
        logic [3:0]  pos;
        logic [11:0] codes;
        logic        wrap;
    } exp_t;

    exp_t       sb [$];
    int         change_cyc [$];
    int         cyc;
    int         passed, total;
    logic [2:0] m_msg [ML];
    logic [3:0] last_pos;

    function automatic logic [11:0] model_codes(input int p);
        logic [11:0] r;
        for (int k = 0; k < 4; k++) r[3*k +: 3] = m_msg[(p + 3 - k) % ML];
        return r;
    endfunction

    task automatic push(input int p, input logic w);
        exp_t e;
        e.pos   = 4'(p);
        e.codes = model_codes(p);
        e.wrap  = w;
        sb.push_back(e);
    endtask

    task automatic set_msg(input logic [23:0] v);
        msg = v;
        for (int i = 0; i < ML; i++) m_msg[i] = v[3*i +: 3];
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press(input bit ld, input bit st, input int hold);
        @(negedge clk);
        if (ld) load_k = 1'b0;
        if (st) step_k = 1'b0;
        repeat (hold) @(negedge clk);
        load_k = 1'b1;
        step_k = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every POS change pops one expected entry; otherwise WRAP must be 0.
    initial begin
        exp_t e;
        last_pos = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (pos !== last_pos) begin
                    change_cyc.push_back(cyc);
                    total++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_unexpected pos=%0d (from %0d) required no change",
                                 pos, last_pos);
                    end else begin
                        e = sb.pop_front();
                        if ({pos, c3, c2, c1, c0, wrap} !== {e.pos, e.codes, e.wrap})
                            $display("FAIL sb_step pos=%0d codes=%h wrap=%b required pos=%0d codes=%h wrap=%b",
                                     pos, {c3, c2, c1, c0}, wrap, e.pos, e.codes, e.wrap);
                        else
                            passed++;
                    end
                end else begin
                    total++;
                    if (wrap !== 1'b0)
                        $display("FAIL wrap_spurious wrap=%b required 0 at pos=%0d", wrap, pos);
                    else
                        passed++;
                end
            end
            last_pos = pos;
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        load_k = 1'b1;
        step_k = 1'b1;
        run_sw = 1'b0;
        dir_sw = 1'b0;
        set_msg('0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({c3, c2, c1, c0} !== 12'hfff)
            $display("FAIL reset_codes codes=%h required fff", {c3, c2, c1, c0});
        else passed++;
        total++;
        if (pos !== 4'd0) $display("FAIL reset_pos pos=%0d required 0", pos);
        else passed++;
        total++;
        if (wrap !== 1'b0) $display("FAIL reset_wrap wrap=%b required 0", wrap);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        total++;
        if ({pos, c3, c2, c1, c0} !== {4'd0, 12'hfff})
            $display("FAIL idle_after_reset pos=%0d codes=%h required 0 fff",
                     pos, {c3, c2, c1, c0});
        else passed++;
    endtask

    task automatic test_load();
        set_msg({3'b111, 3'b111, 3'b111, 3'b111,
                 3'b000, 3'b001, 3'b010, 3'b011});
        @(negedge clk);
        load_k = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({c3, c2, c1, c0} !== 12'hfff)
            $display("FAIL load_early codes=%h required fff", {c3, c2, c1, c0});
        else passed++;
        @(negedge clk);
        total++;
        if ({pos, c3, c2, c1, c0} !== {4'd0, model_codes(0)})
            $display("FAIL load_fpga pos=%0d codes=%h required 0 %h",
                     pos, {c3, c2, c1, c0}, model_codes(0));
        else passed++;
        repeat (5) @(negedge clk);
        load_k = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_run_left();
        bit ok;
        change_cyc.delete();
        for (int p = 1; p <= ML; p++) push(p % ML, p == ML);
        @(negedge clk);
        dir_sw = 1'b0;
        run_sw = 1'b1;
        wait_drain(150, ok);
        total++;
        if (!ok) $display("FAIL run_drain left=%0d required 0", sb.size());
        else passed++;
        total++;
        if (change_cyc.size() != ML)
            $display("FAIL run_count steps=%0d required %0d", change_cyc.size(), ML);
        else passed++;
        for (int i = 1; i < change_cyc.size(); i++) begin
            total++;
            if (change_cyc[i] - change_cyc[i-1] != TD)
                $display("FAIL run_interval gap=%0d required %0d",
                         change_cyc[i] - change_cyc[i-1], TD);
            else passed++;
        end
        run_sw = 1'b0;
        dir_sw = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_step_hold();
        bit ok;
        push(ML - 1, 1'b1);
        press(1'b0, 1'b1, 20);
        repeat (4) @(negedge clk);
        wait_drain(1, ok);
        total++;
        if (!ok) $display("FAIL step_hold left=%0d required 0", sb.size());
        else passed++;
    endtask

    task automatic test_load_step_collide();
        bit ok;
        push(6, 1'b0);
        push(5, 1'b0);
        press(1'b0, 1'b1, 3);
        press(1'b0, 1'b1, 3);
        set_msg({3'b000, 3'b111, 3'b111, 3'b010,
                 3'b110, 3'b110, 3'b100, 3'b101});
        push(0, 1'b0);
        press(1'b1, 1'b1, 3);
        wait_drain(10, ok);
        total++;
        if (!ok) $display("FAIL collide left=%0d required 0", sb.size());
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        push(1, 1'b0);
        push(2, 1'b0);
        push(3, 1'b0);
        @(negedge clk);
        dir_sw = 1'b0;
        run_sw = 1'b1;
        wait_drain(60, ok);
        total++;
        if (!ok || pos !== 4'd3)
            $display("FAIL mid_run_reach pos=%0d required 3", pos);
        else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pos, c3, c2, c1, c0, wrap} !== {4'd0, 12'hfff, 1'b0})
            $display("FAIL async_reset pos=%0d codes=%h wrap=%b required 0 fff 0",
                     pos, {c3, c2, c1, c0}, wrap);
        else passed++;
        run_sw = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        total++;
        if ({pos, c3, c2, c1, c0} !== {4'd0, 12'hfff})
            $display("FAIL post_reset pos=%0d codes=%h required 0 fff",
                     pos, {c3, c2, c1, c0});
        else passed++;
    endtask

    task automatic test_pause_display();
        int shown, blanked;
        set_msg({3'b111, 3'b111, 3'b111, 3'b111,
                 3'b101, 3'b110, 3'b100, 3'b011});
        press(1'b1, 1'b0, 3);
        shown   = 0;
        blanked = 0;
        for (int i = 0; i < 4 * TD; i++) begin
            @(negedge clk);
            if ({c3, c2, c1, c0} === model_codes(0)) shown++;
            if ({c3, c2, c1, c0} === 12'hfff) blanked++;
        end
`ifdef HEX_SCROLL_BLINK_EN
        total++;
        if (shown == 0 || blanked == 0)
            $display("FAIL blink shown=%0d blanked=%0d required both nonzero",
                     shown, blanked);
        else passed++;
`else
        total++;
        if (shown != 4 * TD)
            $display("FAIL pause_steady shown=%0d required %0d", shown, 4 * TD);
        else passed++;
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_load();
        test_run_left();
        test_step_hold();
        test_load_step_collide();
        test_reset_mid_run();
        test_pause_display();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hex_msg_scroller.md
Name: hex_msg_scroller

Overview:
Sequential driver for the character-code side of the DE1 seven-segment path. It holds a short message of 3-bit character codes and produces four per-digit codes for the HEX3..HEX0 glyph decoders. It scrolls the message left or right at a programmable rate, or single-steps it from a pushbutton. It sits between board switches/keys and the per-digit segment decoders.

Parameters:
MSG_LEN, 8, number of characters in the message ring; legal range 4..16.
TICK_DIV, 25000000, CLOCK_50 cycles per scroll step in RUN (0.5 s); minimum 2.
POS_W, 4, width of the position counter; must satisfy 2^POS_W >= MSG_LEN.

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET_N  input  1  asynchronous active-low reset
MSG  input  3*MSG_LEN  message codes; char i occupies bits [3i+2:3i]
LOAD_KEY  input  1  active-low pushbutton; captures MSG
STEP_KEY  input  1  active-low pushbutton; single step while paused
RUN_SW  input  1  level switch; 1 = auto scroll, 0 = pause
DIR_SW  input  1  level switch; 0 = scroll left, 1 = scroll right
CODE3  output  3  code for leftmost digit (HEX3)
CODE2  output  3  code for HEX2
CODE1  output  3  code for HEX1
CODE0  output  3  code for rightmost digit (HEX0)
POS  output  POS_W  current ring offset
WRAP  output  1  one-cycle pulse when POS wraps

Behaviour:
- Character set: 000 A, 001 G, 010 P, 011 F, 100 E, 101 H, 110 L, 111 blank.
- Reset is asynchronous and active-low. Reset values: msg_q all 111, POS 0, prescaler 0, state PAUSE, WRAP 0, CODE3..0 all 111, synchronizer flops 1 for keys and 0 for switches.
- All four control inputs pass through a 2-flop synchronizer.
- Keys use falling-edge detection. A key action takes effect on the 3rd rising edge after the key falls. One press causes exactly one action, however long the key is held.
- Switch changes take effect 2 cycles after the input change.
- Outputs come only from registered state. There is no combinational path from input to output.
- CODEk = msg_q[(POS + 3 - k) mod MSG_LEN]. CODE3 therefore shows char POS.
- The state machine has two states, PAUSE and RUN:
  - PAUSE to RUN when the synchronized RUN_SW is 1.
  - RUN to PAUSE when the synchronized RUN_SW is 0. The prescaler clears on entry to PAUSE.
- In RUN, the prescaler counts from 0 to TICK_DIV-1. At the terminal count it returns to 0 and a step occurs.
- In PAUSE, a STEP_KEY edge causes one step. STEP_KEY is ignored in RUN.
- Step with DIR_SW=0: POS = (POS+1) mod MSG_LEN. WRAP pulses when POS goes from MSG_LEN-1 to 0.
- Step with DIR_SW=1: POS = (POS-1) mod MSG_LEN. WRAP pulses when POS goes from 0 to MSG_LEN-1.
- WRAP is registered and high for exactly the cycle in which the new POS is visible.
- A LOAD_KEY edge does the following: msg_q = MSG, POS = 0, prescaler = 0. The state is unchanged and no WRAP pulse occurs.
- If a load and a step occur in the same cycle, the load wins: POS = 0 and the step is discarded.
- A DIR_SW change mid-interval does not restart the prescaler. The next step uses the new direction.
- Asserting reset mid-run returns all outputs immediately to their reset values. After release, the block is in PAUSE and needs a fresh load.

Optional Feature:
Macro HEX_SCROLL_BLINK_EN.
- Defined: while in PAUSE, CODE3..0 are forced to 111 during alternating TICK_DIV-cycle halves, using a free-running blink counter and phase bit cleared on PAUSE entry. The first half is visible and the second half is blank. Outputs are never blanked in RUN.
- Undefined: no blink logic is present, and PAUSE outputs are steady.

Test Plan:
1. Assert RESET_N=0 for 3 cycles, then release -> CODE3..0 = 111,111,111,111, POS=0, WRAP=0 and stays 0 for 100 cycles with RUN_SW=0.
2. Set MSG chars0..7 = 011,010,001,000,111,111,111,111 and press LOAD_KEY -> 3 cycles later CODE3..0 = 011,010,001,000 ("FPGA"), POS=0.
3. Use TICK_DIV=4, DIR_SW=0, RUN_SW=1 after step 2 -> POS increments every 4 cycles. At POS=1, CODE3..0 = 010,001,000,111. After 8 steps POS=0 with a single-cycle WRAP.
4. RUN_SW=0, DIR_SW=1, POS=0, hold STEP_KEY low for 20 cycles -> exactly one step: POS=7, CODE3..0 = 111,011,010,001, WRAP pulses once.
5. Press LOAD_KEY and STEP_KEY so their edges coincide while paused at POS=5 -> POS=0, no WRAP, CODE shows the new MSG from char 0.
6. Pull RESET_N low mid-RUN at POS=3 -> outputs go to reset values with no clock edge required. After release, POS stays 0 with RUN_SW=0. With HEX_SCROLL_BLINK_EN defined, CODE3..0 alternate between the message and 111 every 4 cycles in PAUSE.
